// File: rtl/servo_pwm_decoder_if.sv
// Pin and result bundle for the servo PWM decoder.
// The master side is the decoder; the slave side is the control/LED logic plus the pin driver.
interface servo_pwm_decoder_if;
  logic        pwm_in;
  logic [15:0] position;
  logic        sample_valid;
  logic        pulse_error;
  logic        dir;
  logic        signal_lost;

  modport master (
    input  pwm_in,
    output position,
    output sample_valid,
    output pulse_error,
    output dir,
    output signal_lost
  );

  modport slave (
    output pwm_in,
    input  position,
    input  sample_valid,
    input  pulse_error,
    input  dir,
    input  signal_lost
  );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Measures the high time of an asynchronous servo pulse and maps it back onto the 0..SPAN control scale.
// Also reports per-pulse accept/reject strobes, direction of the last change and loss of signal.
module servo_pwm_decoder #(
  parameter int MIN_PULSE  = 50000,
  parameter int SPAN       = 50000,
  parameter int MIN_ACCEPT = 25000,
  parameter int MAX_ACCEPT = 125000,
  parameter int GLITCH     = 4,
  parameter int TIMEOUT    = 1500000
) (
  input  logic                 mclk,
  input  logic                 rst,
  servo_pwm_decoder_if.master  bus
);

  localparam int HW   = 17;
  localparam int TW   = 21;
  localparam int PW   = 16;
  localparam int GW   = (GLITCH > 1) ? $clog2(GLITCH + 1) : 1;
  // Sync pipeline refill plus filter depth: a low seen right after reset may be stale reset state.
  localparam int QUAL = GLITCH + 2;
  localparam int LW   = $clog2(QUAL + 1);

  localparam logic signed [17:0] MIN_PULSE_S = 18'(MIN_PULSE);
  localparam logic signed [17:0] SPAN_S      = 18'(SPAN);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  logic                sync_p0;
  logic                sync_p1;
  logic [GW-1:0]       glitch_cnt;
  logic                filt_p2;
  logic                filt_prev;
  logic                rise;
  logic                fall;

  state_t              state;
  logic [HW-1:0]       high_cnt;
  logic [LW-1:0]       low_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [PW-1:0]       position;
  logic                sample_valid;
  logic                pulse_error;
  logic                dir;
  logic                signal_lost;

  logic signed [17:0]  offset;
  logic [PW-1:0]       new_pos;
  logic                accept;

  function automatic logic [PW-1:0] sat_position(input logic signed [17:0] v);
    if (v < 18'sd0) begin
      return '0;
    end else if (v > SPAN_S) begin
      return PW'(SPAN);
    end else begin
      return v[PW-1:0];
    end
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: glitch-filtered level
  always_ff @(posedge mclk) begin
    if (rst) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      glitch_cnt <= '0;
      filt_p2    <= 1'b0;
      filt_prev  <= 1'b0;
    end else begin
      sync_p0   <= bus.pwm_in;
      sync_p1   <= sync_p0;
      filt_prev <= filt_p2;
      if (sync_p1 != filt_p2) begin
        if (glitch_cnt == GW'(GLITCH - 1)) begin
          filt_p2    <= sync_p1;
          glitch_cnt <= '0;
        end else begin
          glitch_cnt <= glitch_cnt + GW'(1);
        end
      end else begin
        glitch_cnt <= '0;
      end
    end
  end

  assign rise    = filt_p2 & ~filt_prev;
  assign fall    = ~filt_p2 & filt_prev;
  assign offset  = $signed({1'b0, high_cnt}) - MIN_PULSE_S;
  assign new_pos = sat_position(offset);
  assign accept  = (state == MEASURE) && fall &&
                   (high_cnt >= HW'(MIN_ACCEPT)) && (high_cnt <= HW'(MAX_ACCEPT));

  // Stage p3: width measurement, evaluation and registered outputs
  always_ff @(posedge mclk) begin
    if (rst) begin
      state        <= WAIT_LOW;
      high_cnt     <= '0;
      low_cnt      <= '0;
      tmo_cnt      <= '0;
      position     <= PW'(SPAN / 2);
      sample_valid <= 1'b0;
      pulse_error  <= 1'b0;
      dir          <= 1'b1;
      signal_lost  <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      pulse_error  <= 1'b0;

      case (state)
        WAIT_LOW: begin
          if (sync_p1) begin
            low_cnt <= '0;
          end else if (low_cnt != LW'(QUAL - 1)) begin
            low_cnt <= low_cnt + LW'(1);
          end else if (!filt_p2) begin
            low_cnt <= '0;
            state   <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            high_cnt <= HW'(1);
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          if (fall) begin
            state <= WAIT_RISE;
            if (!accept) begin
              pulse_error <= 1'b1;
            end
          end else if (filt_p2) begin
            if (high_cnt == HW'(MAX_ACCEPT)) begin
              // Too long to ever be valid: drop it and wait for a clean low before re-arming
              high_cnt    <= HW'(MAX_ACCEPT + 1);
              pulse_error <= 1'b1;
              low_cnt     <= '0;
              state       <= WAIT_LOW;
            end else begin
              high_cnt <= high_cnt + HW'(1);
            end
          end
        end
        default: begin
          state <= WAIT_LOW;
        end
      endcase

      // An accept on the same cycle the timeout would expire takes priority
      if (accept) begin
        position     <= new_pos;
        sample_valid <= 1'b1;
        if (new_pos > position) begin
          dir <= 1'b1;
        end else if (new_pos < position) begin
          dir <= 1'b0;
        end
        tmo_cnt     <= '0;
        signal_lost <= 1'b0;
      end else if (tmo_cnt != TW'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          signal_lost <= 1'b1;
        end
      end
    end
  end

  assign bus.position     = position;
  assign bus.sample_valid = sample_valid;
  assign bus.pulse_error  = pulse_error;
  assign bus.dir          = dir;
  assign bus.signal_lost  = signal_lost;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder, run with time-scaled parameters (1/1000 of the real timing).
// The stimulus side predicts each pulse's outcome from its width; a monitor pops and compares on every strobe.
module tb_servo_pwm_decoder;

  localparam int MIN_PULSE  = 50;
  localparam int SPAN       = 50;
  localparam int MIN_ACCEPT = 25;
  localparam int MAX_ACCEPT = 125;
  localparam int GLITCH     = 4;
  localparam int TIMEOUT    = 1500;
  // Pin-to-strobe latency: two sync flops plus the filter hold time
  localparam int LAT        = GLITCH + 2;

  logic mclk  = 1'b0;
  logic rst   = 1'b1;
  logic rst_q = 1'b1;
  int   cyc   = 0;

  servo_pwm_decoder_if bus ();

  servo_pwm_decoder #(
    .MIN_PULSE  (MIN_PULSE),
    .SPAN       (SPAN),
    .MIN_ACCEPT (MIN_ACCEPT),
    .MAX_ACCEPT (MAX_ACCEPT),
    .GLITCH     (GLITCH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    bit          is_err;
    logic [15:0] pos;
    bit          dir;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_pos;
  bit   model_dir;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, want);
    end
  endtask

  function automatic int ref_pos(input int w);
    int p;
    p = w - MIN_PULSE;
    if (p < 0) p = 0;
    if (p > SPAN) p = SPAN;
    return p;
  endfunction

  // Predict the outcome of a pulse of width w, then drive it (optionally with a 3-cycle dropout)
  task automatic issue(input int w, input int drop_at, input int gap);
    exp_t e;
    int   rise_at;
    int   p;
    rise_at = cyc + 1;
    e.at    = rise_at + ((w > MAX_ACCEPT) ? MAX_ACCEPT : w) + LAT;
    if (w < MIN_ACCEPT || w > MAX_ACCEPT) begin
      e.is_err = 1'b1;
    end else begin
      e.is_err = 1'b0;
      p = ref_pos(w);
      if (p > model_pos) model_dir = 1'b1;
      else if (p < model_pos) model_dir = 1'b0;
      model_pos = p;
    end
    e.pos = 16'(model_pos);
    e.dir = model_dir;
    sb.push_back(e);
    bus.pwm_in = 1'b1;
    if (drop_at > 0) begin
      repeat (drop_at) @(negedge mclk);
      bus.pwm_in = 1'b0;
      repeat (3) @(negedge mclk);
      bus.pwm_in = 1'b1;
      repeat (w - drop_at - 3) @(negedge mclk);
    end else begin
      repeat (w) @(negedge mclk);
    end
    bus.pwm_in = 1'b0;
    repeat (gap) @(negedge mclk);
  endtask

  task automatic check_reset();
    check("rst_position", bus.position, SPAN / 2);
    check("rst_sample_valid", bus.sample_valid, 0);
    check("rst_pulse_error", bus.pulse_error, 0);
    check("rst_dir", bus.dir, 1);
    check("rst_signal_lost", bus.signal_lost, 1);
  endtask

  // Monitor: pops an expectation on every strobe and tracks the expected loss-of-signal level
  exp_t mon_e;
  int   last_acc = 0;
  bit   have_acc = 1'b0;
  bit   exp_lost;

  always @(negedge mclk) begin
    if (rst_q) begin
      have_acc = 1'b0;
    end else begin
      check("strobe_overlap", int'(bus.sample_valid & bus.pulse_error), 0);
      if (bus.sample_valid || bus.pulse_error) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe at cycle %0d: sample_valid=%0b pulse_error=%0b, expected no strobe",
                   cyc, bus.sample_valid, bus.pulse_error);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_is_error", int'(bus.pulse_error), int'(mon_e.is_err));
          check("strobe_cycle", cyc, mon_e.at);
          check("position", bus.position, mon_e.pos);
          check("dir", bus.dir, mon_e.dir);
          if (!mon_e.is_err) begin
            have_acc = 1'b1;
            last_acc = mon_e.at;
          end
        end
      end
      while (sb.size() > 0 && sb[0].at < cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_strobe at cycle %0d: no strobe seen, expected one at cycle %0d", cyc, mon_e.at);
      end
      exp_lost = !have_acc || ((cyc - last_acc) >= TIMEOUT);
      check("signal_lost", int'(bus.signal_lost), int'(exp_lost));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int gap;
    int drop;
    int waited;

    bus.pwm_in = 1'b0;
    repeat (3) @(negedge mclk);
    check_reset();
    rst       = 1'b0;
    model_pos = SPAN / 2;
    model_dir = 1'b1;
    repeat (100) @(negedge mclk);

    // Centre pulse, then full-scale up and clamped-down sequence
    issue(75, 0, 30);
    issue(110, 0, 30);
    issue(40, 0, 30);
    issue(50, 0, 30);

    // Short and over-long rejects, then the accept-window boundaries
    issue(20, 0, 30);
    issue(130, 0, 30);
    issue(24, 0, 30);
    issue(25, 0, 30);
    issue(125, 0, 30);
    issue(126, 0, 30);
    issue(75, 0, 30);

    // Sub-threshold glitches on a low line and a dropout inside a pulse
    for (int i = 0; i < 3; i++) begin
      bus.pwm_in = 1'b1;
      repeat (3) @(negedge mclk);
      bus.pwm_in = 1'b0;
      repeat (20) @(negedge mclk);
    end
    issue(75, 30, 30);

    // Loss of signal after the last accept, then recovery
    issue(75, 0, TIMEOUT + 100);
    issue(60, 0, 30);

    // Reset in the middle of a pulse: the rest of it must be ignored
    bus.pwm_in = 1'b1;
    repeat (30) @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    check_reset();
    rst       = 1'b0;
    model_pos = SPAN / 2;
    model_dir = 1'b1;
    repeat (45) @(negedge mclk);
    bus.pwm_in = 1'b0;
    repeat (40) @(negedge mclk);
    issue(75, 0, 30);

    // Randomized widths across and beyond the accept window
    for (int i = 0; i < 40; i++) begin
      w    = $urandom_range(10, 140);
      gap  = $urandom_range(20, 60);
      drop = 0;
      if (w > 40 && $urandom_range(0, 3) == 0) drop = $urandom_range(5, w - 10);
      issue(w, drop, gap);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 500) begin
      @(negedge mclk);
      waited++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
